// File: rtl/instr_encoder.sv
// RV32I instruction assembler: field-level requests in, encoded 32-bit words plus
// word-aligned preload addresses out, through a two-stage valid/ready pipeline.
module instr_encoder #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_illegal,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int          STAGES = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    logic [STAGES:1] vld_pipe;
    req_t            s1_req;
    logic            accept, s1_adv, out_fire;
    logic [31:0]     enc_word;
    logic            enc_bad;

    assign out_fire  = vld_pipe[2] && out_ready;
    assign s1_adv    = vld_pipe[1] && (!vld_pipe[2] || out_fire);
    assign in_ready  = !clr && (!vld_pipe[1] || s1_adv);
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_pipe[2];

    // Sign-representability: all bits above the sign bit must copy it.
    function automatic logic fits(input logic [31:0] v, input int msb);
        logic [31:0] hi;
        hi = $signed(v) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

    always_comb begin
        req_t r;
        r        = s1_req;
        enc_word = NOP;
        enc_bad  = (r.op[1:0] != 2'b11);
        case (r.fmt)
            3'd0: enc_word = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
            3'd1: begin
                // slli/srli/srai carry funct7 above a 5-bit shamt
                if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
                    enc_word = {r.f7, r.imm[4:0], r.rs1, r.f3, r.rd, r.op};
                    enc_bad  = enc_bad || (r.imm[31:5] != '0);
                end else begin
                    enc_word = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
                    enc_bad  = enc_bad || !fits(r.imm, 11);
                end
            end
            3'd2: begin
                enc_word = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
                enc_bad  = enc_bad || !fits(r.imm, 11);
            end
            3'd3: begin
                enc_word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3,
                            r.imm[4:1], r.imm[11], r.op};
                enc_bad  = enc_bad || !fits(r.imm, 12) || r.imm[0];
            end
            3'd4: begin
                enc_word = {r.imm[31:12], r.rd, r.op};
                enc_bad  = enc_bad || (r.imm[11:0] != '0);
            end
            3'd5: begin
                enc_word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
                enc_bad  = enc_bad || !fits(r.imm, 20) || r.imm[0];
            end
            default: enc_bad = 1'b1;
        endcase
        if (enc_bad) enc_word = NOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (clr) begin
            vld_pipe <= '0;
        end else begin
            if (accept)      vld_pipe[1] <= 1'b1;
            else if (s1_adv) vld_pipe[1] <= 1'b0;
            if (s1_adv)        vld_pipe[2] <= 1'b1;
            else if (out_fire) vld_pipe[2] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_req <= '0;
        end else if (accept) begin
            s1_req <= '{fmt: in_fmt, op: in_op, f3: in_funct3, f7: in_funct7,
                        rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr   <= '0;
            out_illegal <= 1'b0;
        end else if (s1_adv && !clr) begin
            out_instr   <= enc_word;
            out_illegal <= enc_bad;
        end
    end

    // Address moves with every consumed word, NOPs included; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        out_addr <= BASE_ADDR;
        else if (clr)      out_addr <= BASE_ADDR;
        else if (out_fire) out_addr <= out_addr + ADDR_W'(4);
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard queue of expected words, checked as the
// DUT presents them; a 4-bit-address twin runs in lockstep to observe wrap.
module tb_instr_encoder;
    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]  in_fmt = '0, in_funct3 = '0;
    logic [6:0]  in_op = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        in_ready_w, out_valid_w, out_illegal_w;
    logic [31:0] out_instr_w;
    logic [3:0]  out_addr_w;

    typedef struct { logic [31:0] instr; logic ill; } exp_t;
    exp_t        q[$];
    logic [7:0]  exp_addr = '0;
    int          checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_illegal(out_illegal), .out_addr(out_addr));

    instr_encoder #(.ADDR_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_instr(out_instr_w),
        .out_illegal(out_illegal_w), .out_addr(out_addr_w));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output side: the head of the queue must be on the bus whenever out_valid is high.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("instr",     out_instr,                q[0].instr);
                chk("illegal",   32'(out_illegal),         32'(q[0].ill));
                chk("addr",      32'(out_addr),            32'(exp_addr));
                chk("valid_w",   32'(out_valid_w),         32'd1);
                chk("instr_w",   out_instr_w,              q[0].instr);
                chk("illegal_w", 32'(out_illegal_w),       32'(q[0].ill));
                chk("addr_w",    32'(out_addr_w),          32'(exp_addr[3:0]));
                if (out_ready) begin
                    void'(q.pop_front());
                    exp_addr += 8'd4;
                end
            end
        end
    end

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Present a request, wait (bounded) for the handshake edge, then queue its expectation.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_ill);
        bit ok = 0;
        drive(fmt, op, f3, f7, rd, rs1, rs2, imm);
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            q.push_back('{instr: exp_instr, ill: exp_ill});
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
        exp_addr = '0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_addr",  32'(out_addr),  32'd0);
    endtask

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(out_valid),   32'd0);
        chk("rst_instr",   out_instr,        32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_addr",    32'(out_addr),    32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        chk("rst_in_ready_w", 32'(in_ready_w), 32'd1);
        out_ready = 1'b1;

        // add x3,x1,x2; word appears on the second edge after the request is presented
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        chk("lat_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();

        // I-type, immediate bounds and shift forms
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h00000013, 1'b1);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        send(3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3,        32'h00311093, 1'b0);
        send(3'd1, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3,        32'h40315093, 1'b0);
        send(3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd32,       32'h00000013, 1'b1);
        drain();

        // B/J/S/U formats plus malformed requests, back to back
        t0 = cyc;
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3,        32'h00000013, 1'b1);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd1,        32'h00000013, 1'b1);
        send(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096,     32'h00000013, 1'b1);
        chk("throughput", 32'(cyc - t0), 32'd4);
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0);
        send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h00000013, 1'b1);
        send(3'd6, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h00000013, 1'b1);
        send(3'd0, 7'h30, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        32'h00000013, 1'b1);
        drain();

        // Backpressure: two held in flight, third refused until release
        out_ready = 1'b0;
        pulse_clr();
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        send(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        drive(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        drain();
        chk("bp_addr_after", 32'(out_addr), 32'd12);

        // Wrap on the 4-bit twin: 0,4,8,C,0
        out_ready = 1'b0;
        pulse_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send(3'd1, 7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, 32'd1,
                 32'h00100013 | (32'(i) << 7), 1'b0);
        drain();
        chk("wrap_addr_w", 32'(out_addr_w), 32'd4);

        // Async reset with two words in flight
        out_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd4, 5'd1, 5'd2, 32'd0, 32'h00208233, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_addr",  32'(out_addr),  32'd0);
        chk("arst_instr", out_instr,      32'd0);
        q.delete();
        exp_addr = '0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("arst_no_stale", 32'(out_valid), 32'd0);
        end
        send(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
        drain();

        // Same scenario flushed by clr
        out_ready = 1'b0;
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
        send(3'd0, 7'h33, 3'd0, 7'h00, 5'd4, 5'd1, 5'd2, 32'd0, 32'h00208233, 1'b0);
        pulse_clr();
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("clr_no_stale", 32'(out_valid), 32'd0);
        end
        send(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
